// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem handshake, one-entry hold buffer, redirect.
// Optional IFU_PERF_CNT_EN adds a consumed-word counter on port fetch_count.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic [31:0] hold_pc;
  logic [31:0] redir_tgt;
  logic        out_free;
  logic        consume;

  assign redir_tgt = redirect_pc & ~32'h3;
  assign out_free  = ~instr_valid | ~stall;
  assign consume   = instr_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_word  <= NOP_WORD;
      instr_pc    <= RESET_PC;
      hold_word   <= NOP_WORD;
      hold_pc     <= RESET_PC;
    end else begin
      // Loads below override this clear when a new word arrives in the same cycle.
      if (consume) begin
        instr_valid <= 1'b0;
        instr_word  <= NOP_WORD;
      end
      if (redirect_valid) begin
        pc          <= redir_tgt;
        instr_valid <= 1'b0;
        instr_word  <= NOP_WORD;
        // An unanswered request must stay up at its old address until acked.
        if (imem_req && !imem_ack) begin
          state <= DRAIN;
        end else begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= redir_tgt;
        end
      end else begin
        case (state)
          IDLE: begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          FETCH: begin
            if (!imem_req) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else if (imem_ack) begin
              pc       <= pc + 32'd4;
              imem_req <= 1'b0;
              if (out_free) begin
                instr_valid <= 1'b1;
                instr_word  <= imem_rdata;
                instr_pc    <= pc;
              end else begin
                hold_word <= imem_rdata;
                hold_pc   <= pc;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (out_free) begin
              instr_valid <= 1'b1;
              instr_word  <= hold_word;
              instr_pc    <= hold_pc;
              state       <= FETCH;
              imem_req    <= 1'b1;
              imem_addr   <= pc;
            end
          end
          DRAIN: begin
            // Stale data is dropped; pc already holds the redirect target.
            if (imem_ack) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count <= 32'd0;
    else if (consume) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit against an in-order fetch-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_pc(instr_pc)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory contents: a fixed scramble of the address, so every word identifies its PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0293;
  endfunction

  // Scoreboard: in-order {pc, word} of every fetch that must reach decode.
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch_addr = RESET_PC;
  int          epoch = 0;
  logic        ack_push = 1'b0;
  logic [31:0] push_addr = 32'h0;

  // Memory model state
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_epoch = 0;
  int          mem_wait = 0;

  // Monitor state
  logic [63:0] mon_e;
  logic        lat_pend = 1'b0;
  logic [31:0] lat_pc = 32'h0;
  logic        hold_pend = 1'b0;
  logic [31:0] h_pc = 32'h0;
  logic [31:0] h_word = 32'h0;
  logic        prev_redir = 1'b0;
  logic [31:0] cons_cnt = 32'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cons_cnt   = 32'h0;
      lat_pend   = 1'b0;
      hold_pend  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      if (!instr_valid) check("nop_when_invalid", instr_word, NOP_WORD);
      if (prev_redir) check("redirect_clears_valid", {31'h0, instr_valid}, 32'h0);
      if (lat_pend) begin
        check("ack_latency_valid", {31'h0, instr_valid}, 32'h1);
        check("ack_latency_pc", instr_pc, lat_pc);
        check("ack_latency_word", instr_word, mem_word(lat_pc));
      end
      if (hold_pend) begin
        check("stall_hold_valid", {31'h0, instr_valid}, 32'h1);
        check("stall_hold_pc", instr_pc, h_pc);
        check("stall_hold_word", instr_word, h_word);
      end
`ifdef IFU_PERF_CNT_EN
      check("fetch_count", fetch_count, cons_cnt);
`endif
      if (instr_valid && !stall) begin
        cons_cnt = cons_cnt + 32'd1;
        if (exp_q.size() == 0) begin
          check("consume_unexpected_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("consume_pc", instr_pc, mon_e[63:32]);
          check("consume_word", instr_word, mon_e[31:0]);
        end
      end
      // Everything still queued at a redirect was fetched down the wrong path.
      if (redirect_valid) exp_q.delete();
      lat_pend   = ack_push && (!instr_valid || !stall);
      lat_pc     = push_addr;
      hold_pend  = instr_valid && stall && !redirect_valid;
      h_pc       = instr_pc;
      h_word     = instr_word;
      prev_redir = redirect_valid;
    end
  end

  task automatic check_reset_outputs();
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr_word", instr_word, NOP_WORD);
    check("rst_instr_pc", instr_pc, RESET_PC);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mem_busy       = 1'b0;
    epoch++;
    exp_fetch_addr = RESET_PC;
    ack_push       = 1'b0;
    imem_ack       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic        rnd;
    logic        quiet;
    logic        redir;
    logic [31:0] tgt;
    logic        did_rst;
    int          r;

    did_rst = 1'b0;
    #12;
    check_reset_outputs();
    #11 rst_n = 1'b1;

    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      #1;
      ack_push = 1'b0;

      // Asynchronous reset in the middle of an outstanding fetch.
      if (it >= 1500 && !did_rst && imem_req) begin
        did_rst = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        continue;
      end

      rnd   = (it >= 40);
      quiet = (it >= 2900);
      redir = rnd && !quiet && ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = 32'($urandom_range(0, 1023));
      redirect_valid = redir;
      redirect_pc    = tgt;
      stall          = rnd && !quiet && ($urandom_range(0, 99) < 35);

      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy  = 1'b1;
          mem_addr  = imem_addr;
          mem_epoch = epoch;
          r = $urandom_range(0, 9);
          if (!rnd || r < 5) mem_wait = 0;
          else if (r < 8) mem_wait = 1;
          else mem_wait = $urandom_range(2, 4);
        end else begin
          check("req_addr_stable", imem_addr, mem_addr);
        end
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
          if (!redir && mem_epoch == epoch) begin
            check("fetch_addr", mem_addr, exp_fetch_addr);
            exp_q.push_back({mem_addr, mem_word(mem_addr)});
            exp_fetch_addr = exp_fetch_addr + 32'd4;
            ack_push  = 1'b1;
            push_addr = mem_addr;
          end
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          mem_wait--;
        end
      end else begin
        check("req_held_until_ack", {31'h0, mem_busy}, 32'h0);
        mem_busy   = 1'b0;
        // Stray acks while idle carry junk that must never surface.
        imem_ack   = rnd && ($urandom_range(0, 9) == 0);
        imem_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end

      if (redir) begin
        epoch++;
        exp_fetch_addr = tgt & ~32'h3;
      end
    end

    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("final_backlog_small", {31'h0, exp_q.size() <= 2}, 32'h1);
    check("reset_exercised", {31'h0, did_rst}, 32'h1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
